// File: rtl/data_fifo_pkg.sv
// Shared constants and byte type for the data FIFO buffer.
package data_fifo_pkg;

   localparam int unsigned FIFO_DATA_W        = 8;
   localparam int unsigned FIFO_DEFAULT_DEPTH = 16;

   typedef logic [FIFO_DATA_W-1:0] fifo_byte_t;

endpackage : data_fifo_pkg

// File: rtl/data_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module data_fifo_mem
   import data_fifo_pkg::*;
#(
   parameter int unsigned DEPTH  = FIFO_DEFAULT_DEPTH,
   parameter int unsigned DATA_W = FIFO_DATA_W,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : data_fifo_mem

// File: rtl/data_fifo_buffer.sv
// Byte FIFO feeding the data FIFO interface: registered read data, no
// fall-through, sticky overflow on writes dropped while full.
module data_fifo_buffer
   import data_fifo_pkg::*;
#(
   parameter int unsigned DEPTH  = FIFO_DEFAULT_DEPTH,
   parameter int unsigned DATA_W = FIFO_DATA_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       fifo_request_data,
   output logic                       fifo_empty,
   output logic [DATA_W-1:0]          fifo_data,
   output logic                       fifo_overflow,
   input  logic                       overflow_clr,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] rd_byte;

   logic full;
   logic rd_acc;
   logic wr_acc;
   logic wr_drop;
   logic mem_we;

   // A full buffer still accepts a write when a read frees a slot this cycle.
   assign full    = (count == CNT_W'(DEPTH));
   assign rd_acc  = fifo_request_data && (count != '0);
   assign wr_acc  = wr_en && (!full || rd_acc);
   assign wr_drop = wr_en && full && !rd_acc;
   assign mem_we  = wr_acc && !rst;

   data_fifo_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (rd_byte)
   );

   // Pointers, occupancy, output register and overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         fifo_data     <= '0;
         fifo_overflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (rd_acc) begin
            rd_ptr    <= rd_ptr + PTR_W'(1);
            fifo_data <= rd_byte;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (wr_drop) begin
            fifo_overflow <= 1'b1;
         end else if (overflow_clr) begin
            fifo_overflow <= 1'b0;
         end
      end
   end

   assign fifo_empty = (count == '0);
   assign fifo_count = count;

endmodule : data_fifo_buffer

// File: tb/tb_data_fifo_buffer.sv
// Directed and randomized bench for data_fifo_buffer against a queue model.
module tb_data_fifo_buffer;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_en;
   logic [7:0]       wr_data;
   logic             fifo_request_data;
   logic             fifo_empty;
   logic [7:0]       fifo_data;
   logic             fifo_overflow;
   logic             overflow_clr;
   logic [CNT_W-1:0] fifo_count;

   int vectors    = 0;
   int miscompares = 0;

   logic [7:0] q[$];
   logic [7:0] m_data = 8'h00;
   logic       m_ovf  = 1'b0;

   data_fifo_buffer #(
      .DEPTH  (DEPTH),
      .DATA_W (8)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .wr_en             (wr_en),
      .wr_data           (wr_data),
      .fifo_request_data (fifo_request_data),
      .fifo_empty        (fifo_empty),
      .fifo_data         (fifo_data),
      .fifo_overflow     (fifo_overflow),
      .overflow_clr      (overflow_clr),
      .fifo_count        (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural reference: a byte queue with the FIFO's acceptance rules.
   task automatic model_step(input logic wr, input logic [7:0] d, input logic rq,
                             input logic clr, input logic rs);
      bit was_full, rd, drop;
      if (rs) begin
         q.delete();
         m_data = 8'h00;
         m_ovf  = 1'b0;
      end else begin
         was_full = (q.size() == DEPTH);
         rd       = rq && (q.size() > 0);
         drop     = wr && was_full && !rd;
         if (rd) m_data = q.pop_front();
         if (wr && !drop) q.push_back(d);
         if (drop)     m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
      end
   endtask

   // One clock with the given inputs, then compare all outputs with the model.
   task automatic cyc(input logic wr, input logic [7:0] d, input logic rq,
                      input logic clr, input logic rs);
      wr_en             = wr;
      wr_data           = d;
      fifo_request_data = rq;
      overflow_clr      = clr;
      rst               = rs;
      @(posedge clk);
      #1;
      model_step(wr, d, rq, clr, rs);
      check("count", 32'(fifo_count), 32'(q.size()));
      check("empty", 32'(fifo_empty), 32'(q.size() == 0));
      check("data", 32'(fifo_data), 32'(m_data));
      check("overflow", 32'(fifo_overflow), 32'(m_ovf));
   endtask

   initial begin
      wr_en = 0; wr_data = 0; fifo_request_data = 0; overflow_clr = 0; rst = 1;

      // Reset then idle
      cyc(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0, 0);
      check("rst_empty", 32'(fifo_empty), 32'd1);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_data", 32'(fifo_data), 32'h00);
      check("rst_ovf", 32'(fifo_overflow), 32'd0);

      // Three writes then three reads
      cyc(1, 8'hA1, 0, 0, 0);
      cyc(1, 8'hB2, 0, 0, 0);
      cyc(1, 8'hC3, 0, 0, 0);
      cyc(0, 8'h00, 1, 0, 0); check("rd_a1", 32'(fifo_data), 32'hA1);
      cyc(0, 8'h00, 1, 0, 0); check("rd_b2", 32'(fifo_data), 32'hB2);
      cyc(0, 8'h00, 1, 0, 0); check("rd_c3", 32'(fifo_data), 32'hC3);
      check("empty_after3", 32'(fifo_empty), 32'd1);

      // Overfill: 17 writes, the last is dropped
      for (int i = 0; i < 17; i++) cyc(1, 8'(i), 0, 0, 0);
      check("full_count", 32'(fifo_count), 32'd16);
      check("ovf_set", 32'(fifo_overflow), 32'd1);
      for (int i = 0; i < 16; i++) begin
         cyc(0, 8'h00, 1, 0, 0);
         check("drain", 32'(fifo_data), 32'(i));
      end
      cyc(0, 8'h00, 1, 0, 0);
      check("drain_absent", 32'(fifo_data), 32'h0F);

      // Clear sticky overflow
      cyc(0, 8'h00, 0, 1, 0);
      check("ovf_clr", 32'(fifo_overflow), 32'd0);

      // Full with simultaneous write and read
      for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0, 0, 0);
      cyc(1, 8'h55, 1, 0, 0);
      check("full_rw_count", 32'(fifo_count), 32'd16);
      check("full_rw_ovf", 32'(fifo_overflow), 32'd0);
      check("full_rw_data", 32'(fifo_data), 32'h20);
      for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0, 0);
      check("last_55", 32'(fifo_data), 32'h55);

      // Empty with simultaneous write and request: no fall-through
      cyc(1, 8'h77, 1, 0, 0);
      check("nofall_count", 32'(fifo_count), 32'd1);
      check("nofall_data", 32'(fifo_data), 32'h55);
      cyc(0, 8'h00, 1, 0, 0);
      check("rd_77", 32'(fifo_data), 32'h77);

      // Set and clear in the same cycle: set wins
      for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
      cyc(1, 8'hEE, 0, 1, 0);
      check("set_wins", 32'(fifo_overflow), 32'd1);
      cyc(0, 8'h00, 0, 1, 0);
      check("clr_after", 32'(fifo_overflow), 32'd0);

      // Reset mid-operation overrides concurrent write and read
      cyc(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 5; i++) cyc(1, 8'(8'h40 + i), 0, 0, 0);
      cyc(1, 8'h99, 1, 0, 1);
      check("midrst_count", 32'(fifo_count), 32'd0);
      check("midrst_empty", 32'(fifo_empty), 32'd1);
      cyc(0, 8'h00, 1, 0, 0);
      check("midrst_data", 32'(fifo_data), 32'h00);

      // Randomized traffic in phases biased toward filling then draining
      for (int i = 0; i < 3000; i++) begin
         int unsigned ph;
         logic        w, r, c, s;
         ph = (i / 300) % 3;
         w  = ($urandom_range(99) < (ph == 0 ? 85 : (ph == 1 ? 50 : 20)));
         r  = ($urandom_range(99) < (ph == 0 ? 20 : (ph == 1 ? 50 : 85)));
         c  = ($urandom_range(99) < 4);
         s  = ($urandom_range(999) < 3);
         cyc(w, 8'($urandom), r, c, s);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_data_fifo_buffer

// File: doc/data_fifo_buffer.md
# data_fifo_buffer

Synchronous 8-bit data FIFO that sits directly upstream of the data FIFO interface. It drives `fifo_empty`, `fifo_data` and `fifo_overflow` toward the consuming stage and pops one byte per accepted `fifo_request_data`. The producer side has no back-pressure. A write to a full buffer is dropped and raises a sticky overflow flag.

## Interface
Parameters:
- `DEPTH`, 16: number of byte entries; power of two, ≥ 2.
- `DATA_W`, 8: data width; fixed at 8 for this interface.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  producer write strobe.
- `wr_data`  in  DATA_W  producer byte, sampled when `wr_en`=1.
- `fifo_request_data`  in  1  consumer pop request.
- `fifo_empty`  out  1  no stored data.
- `fifo_data`  out  DATA_W  registered read data.
- `fifo_overflow`  out  1  sticky: a write was dropped while full.
- `overflow_clr`  in  1  clears `fifo_overflow`.
- `fifo_count`  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

## Operation
- Storage is a circular buffer with `wr_ptr` and `rd_ptr` of $clog2(DEPTH) bits, plus an occupancy counter `count`.
- Pointers wrap from DEPTH-1 to 0 with no special-case logic; DEPTH is a power of two.
- Write accepted when `wr_en` && (count < DEPTH || read accepted same cycle). An accepted write stores to `mem[wr_ptr]` and increments `wr_ptr`.
- Read accepted when `fifo_request_data` && count > 0. An accepted read loads `fifo_data <= mem[rd_ptr]` and increments `rd_ptr`.
- `count` rules per cycle:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on both or neither.
- No fall-through: when count = 0, a simultaneous write and request stores the write and ignores the read.
- When count = DEPTH, a simultaneous write and read are both accepted; count stays DEPTH and no overflow is raised.
- Dropped write (`wr_en` && count = DEPTH && no read accepted): sets `fifo_overflow`; storage and pointers are unchanged.
- `fifo_overflow` stays set until `overflow_clr` or `rst`. If set and clear coincide, set wins.
- A request while empty is ignored; `fifo_data` holds its last value.
- `fifo_empty` = (count == 0), driven combinationally from the registered count.

## Timing
- Reset values:
  - `wr_ptr` = 0, `rd_ptr` = 0, `count` = 0.
  - `fifo_empty` = 1, `fifo_data` = 8'h00, `fifo_overflow` = 0, `fifo_count` = 0.
  - Memory contents are not reset.
- Read latency: request sampled at edge N; `fifo_data` valid after edge N and held until the next accepted read.
- Write-to-visible: a write at edge N clears `fifo_empty` after edge N; the earliest read of that byte is accepted at edge N+1.
- Throughput: one write and one read per cycle sustained.
- Reset mid-operation: `rst` high at an edge discards all contents and overrides any concurrent write or read. Outputs show reset values after that edge.

## Structure
- Package `data_fifo_pkg` holds:
  - `FIFO_DATA_W` = 8 and `FIFO_DEFAULT_DEPTH` = 16.
  - `typedef logic [FIFO_DATA_W-1:0] fifo_byte_t`.
- Sub-module `data_fifo_mem`: simple dual-port register array with synchronous write port and asynchronous read port. Pointer, count, flag and output-register control stay in `data_fifo_buffer`.

## Test plan
- Reset, then idle 3 cycles -> `fifo_empty`=1, `fifo_count`=0, `fifo_data`=8'h00, `fifo_overflow`=0.
- Write 8'hA1, 8'hB2, 8'hC3 on consecutive cycles, then request 3 cycles -> `fifo_data` = A1, B2, C3 one cycle after each request; `fifo_empty`=1 after the third read.
- Write 17 bytes 8'h00..8'h10 with DEPTH=16 and no reads -> `fifo_count`=16 and `fifo_overflow`=1 after the 17th write. Drain 16 -> data 00..0F; 8'h10 is absent.
- Fill to 16, then write 8'h55 and request in the same cycle -> count stays 16, `fifo_overflow`=0, first read returns entry 0. After the remaining 16 reads, the last byte read is 8'h55.
- Empty FIFO, write 8'h77 and request together -> read ignored, `fifo_count`=1, `fifo_data` unchanged; the next request returns 8'h77.
- Overflow set, then assert `overflow_clr` -> flag 0. Load 5 bytes, assert `rst` -> count 0, `fifo_empty`=1; request after reset -> `fifo_data` stays 8'h00.
